// File: rtl/hazard3_fetch_aligner_pkg.sv
// Shared types and constants for the halfword fetch aligner.
package hazard3_fetch_aligner_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int HW_W      = 16;

    typedef struct packed {
        logic            err;
        logic [HW_W-1:0] data;
    } hw_t;

    localparam hw_t HW_NONE = '0;

    // RISC-V length rule: low two bits 2'b11 mean a 32-bit encoding.
    function automatic logic is_32bit(input logic [HW_W-1:0] hw);
        return hw[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/hazard3_fetch_aligner.sv
// Halfword instruction buffer (3 deep) between fetch queue and decompressor; fetch to instr_* in 1 cycle.
// Backpressure: fetch_rdy only while at most one halfword survives this cycle's dispatch.
module hazard3_fetch_aligner
    import hazard3_fetch_aligner_pkg::*;
#(
    parameter int          EXTENSION_C  = 1,
    parameter logic [31:0] RESET_VECTOR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_vld,
    output logic        fetch_rdy,
    input  logic [31:0] fetch_data,
    input  logic        fetch_err,
    input  logic        jump_now,
    input  logic [31:0] jump_target,
    output logic        instr_vld,
    output logic [31:0] instr_data,
    output logic        instr_err,
    output logic [31:0] instr_pc,
    input  logic        dispatch,
    input  logic        dispatch_32
);

    hw_t         buf_q [BUF_DEPTH];
    hw_t         buf_d [BUF_DEPTH];
    logic [1:0]  level_q, level_d;
    logic        skip_lo_q, skip_lo_d;
    logic [31:0] pc_q, pc_d;

    logic [1:0]  consumed_hw;
    logic [1:0]  remain;
    logic        accept;
    hw_t         lo_hw, hi_hw;
    hw_t         win_lo, win_hi;
    logic        lo_is_32;
    logic        unused_jump_lsb;

    assign unused_jump_lsb = jump_target[0];

    always_comb begin
        consumed_hw = 2'd0;
        if (dispatch) begin
            consumed_hw = (EXTENSION_C == 0 || dispatch_32) ? 2'd2 : 2'd1;
        end
        // Over-consumption only happens on an errored lone halfword; clamp to empty.
        remain = (level_q > consumed_hw) ? (level_q - consumed_hw) : 2'd0;
    end

    assign fetch_rdy = (remain <= 2'd1);
    assign accept    = fetch_vld & fetch_rdy & ~jump_now;
    assign lo_hw     = '{err: fetch_err, data: fetch_data[15:0]};
    assign hi_hw     = '{err: fetch_err, data: fetch_data[31:16]};

    always_comb begin
        case (consumed_hw)
            2'd1:    buf_d = '{buf_q[1], buf_q[2], HW_NONE};
            2'd2:    buf_d = '{buf_q[2], HW_NONE, HW_NONE};
            default: buf_d = buf_q;
        endcase
        level_d   = remain;
        skip_lo_d = skip_lo_q;
        pc_d      = pc_q + {29'd0, consumed_hw, 1'b0};

        if (accept) begin
            if (skip_lo_q) begin
                if (remain == 2'd0) buf_d[0] = hi_hw;
                else                buf_d[1] = hi_hw;
                level_d   = remain + 2'd1;
                skip_lo_d = 1'b0;
            end else if (remain == 2'd0) begin
                buf_d[0] = lo_hw;
                buf_d[1] = hi_hw;
                level_d  = 2'd2;
            end else begin
                buf_d[1] = lo_hw;
                buf_d[2] = hi_hw;
                level_d  = 2'd3;
            end
        end

        if (jump_now) begin
            buf_d     = '{HW_NONE, HW_NONE, HW_NONE};
            level_d   = 2'd0;
            pc_d      = {jump_target[31:1], 1'b0};
            skip_lo_d = jump_target[1] & (EXTENSION_C != 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= HW_NONE;
            level_q   <= 2'd0;
            skip_lo_q <= 1'b0;
            pc_q      <= RESET_VECTOR;
        end else begin
            buf_q     <= buf_d;
            level_q   <= level_d;
            skip_lo_q <= skip_lo_d;
            pc_q      <= pc_d;
        end
    end

    // Halfwords above the fill level never reach the decompressor.
    assign win_lo   = (level_q >= 2'd1) ? buf_q[0] : HW_NONE;
    assign win_hi   = (level_q >= 2'd2) ? buf_q[1] : HW_NONE;
    assign lo_is_32 = is_32bit(win_lo.data);

    always_comb begin
        if (EXTENSION_C != 0) begin
            instr_vld = (level_q >= 2'd2) ||
                        (level_q == 2'd1 && (!lo_is_32 || win_lo.err));
        end else begin
            instr_vld = (level_q >= 2'd2);
        end
    end

    assign instr_data = {win_hi.data, win_lo.data};
    assign instr_err  = win_lo.err | (win_hi.err & lo_is_32);
    assign instr_pc   = pc_q;

    a_dispatch_needs_vld: assert property (
        @(posedge clk) disable iff (!rst_n) dispatch |-> instr_vld);

    a_dispatch_32_needs_two: assert property (
        @(posedge clk) disable iff (!rst_n)
        (dispatch && dispatch_32 && EXTENSION_C != 0) |-> (level_q >= 2'd2 || win_lo.err));

endmodule

// File: tb/tb_hazard3_fetch_aligner.sv
module tb_hazard3_fetch_aligner;

    localparam logic [31:0] RV = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_vld, fetch_rdy, fetch_err, jump_now, dispatch, dispatch_32;
    logic        instr_vld, instr_err;
    logic [31:0] fetch_data, jump_target, instr_data, instr_pc;

    logic        n_fetch_vld, n_fetch_rdy, n_fetch_err, n_jump_now, n_dispatch, n_dispatch_32;
    logic        n_instr_vld, n_instr_err;
    logic [31:0] n_fetch_data, n_jump_target, n_instr_data, n_instr_pc;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {err, halfword}, oldest first.
    logic [16:0] mq[$];
    logic [31:0] mpc;
    bit          mskip;

    always #5 clk = ~clk;

    hazard3_fetch_aligner #(.EXTENSION_C(1), .RESET_VECTOR(RV)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy), .fetch_data(fetch_data),
        .fetch_err(fetch_err), .jump_now(jump_now), .jump_target(jump_target),
        .instr_vld(instr_vld), .instr_data(instr_data), .instr_err(instr_err),
        .instr_pc(instr_pc), .dispatch(dispatch), .dispatch_32(dispatch_32));

    hazard3_fetch_aligner #(.EXTENSION_C(0), .RESET_VECTOR(RV)) dut_noc (
        .clk(clk), .rst_n(rst_n),
        .fetch_vld(n_fetch_vld), .fetch_rdy(n_fetch_rdy), .fetch_data(n_fetch_data),
        .fetch_err(n_fetch_err), .jump_now(n_jump_now), .jump_target(n_jump_target),
        .instr_vld(n_instr_vld), .instr_data(n_instr_data), .instr_err(n_instr_err),
        .instr_pc(n_instr_pc), .dispatch(n_dispatch), .dispatch_32(n_dispatch_32));

    function automatic logic m_vld();
        if (mq.size() >= 2) return 1'b1;
        if (mq.size() == 1) return (mq[0][1:0] != 2'b11) || mq[0][16];
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_data();
        logic [15:0] lo, hi;
        lo = (mq.size() >= 1) ? mq[0][15:0] : 16'h0;
        hi = (mq.size() >= 2) ? mq[1][15:0] : 16'h0;
        return {hi, lo};
    endfunction

    function automatic logic m_err();
        if (mq.size() == 0) return 1'b0;
        if (mq[0][16]) return 1'b1;
        return (mq.size() >= 2) && mq[1][16] && (mq[0][1:0] == 2'b11);
    endfunction

    function automatic logic m_rdy();
        int c;
        c = dispatch ? (dispatch_32 ? 2 : 1) : 0;
        return (mq.size() - c) <= 1;
    endfunction

    task automatic m_reset();
        mq.delete();
        mpc   = RV;
        mskip = 1'b0;
    endtask

    task automatic drv(input logic fv, input logic [31:0] fd, input logic fe, input logic jn,
                       input logic [31:0] jt, input logic d, input logic d32);
        fetch_vld = fv; fetch_data = fd; fetch_err = fe;
        jump_now = jn; jump_target = jt; dispatch = d; dispatch_32 = d32;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Advances the model with the currently driven inputs, then one clock.
    task automatic tick();
        int c;
        bit rdy;
        logic [16:0] tmp;
        if (jump_now) begin
            mq.delete();
            mpc   = {jump_target[31:1], 1'b0};
            mskip = jump_target[1];
        end else begin
            c   = dispatch ? (dispatch_32 ? 2 : 1) : 0;
            rdy = (mq.size() - c) <= 1;
            for (int i = 0; i < c; i++) if (mq.size() > 0) tmp = mq.pop_front();
            mpc = mpc + 32'(2 * c);
            if (fetch_vld && rdy) begin
                if (!mskip) mq.push_back({fetch_err, fetch_data[15:0]});
                mq.push_back({fetch_err, fetch_data[31:16]});
                mskip = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_jump(input logic [31:0] t);
        drv(1'b0, 32'h0, 1'b0, 1'b1, t, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_reset();
        #7;
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", instr_vld); end
        total++; if (instr_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", instr_data); end
        total++; if (instr_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", instr_err); end
        total++; if (fetch_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", fetch_rdy); end
        total++; if (instr_pc !== RV) begin bad++; $display("FAIL reset_pc got=%h want=%h", instr_pc, RV); end
        total++; if (n_instr_vld !== 1'b0) begin bad++; $display("FAIL reset_noc_vld got=%b want=0", n_instr_vld); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addi();
        drv(1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        total++; if (fetch_rdy !== 1'b1) begin bad++; $display("FAIL addi_rdy got=%b want=1", fetch_rdy); end
        tick();
        idle();
        total++; if (instr_vld !== 1'b1) begin bad++; $display("FAIL addi_vld got=%b want=1", instr_vld); end
        total++; if (instr_pc !== RV) begin bad++; $display("FAIL addi_pc got=%h want=%h", instr_pc, RV); end
        total++; if (instr_data !== 32'h00000013) begin bad++; $display("FAIL addi_data got=%h want=00000013", instr_data); end
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        idle();
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL addi_empty got=%b want=0", instr_vld); end
        total++; if (instr_pc !== RV + 32'd4) begin bad++; $display("FAIL addi_pc4 got=%h want=%h", instr_pc, RV + 32'd4); end
    endtask

    task automatic test_two_cli();
        do_jump(32'h0);
        drv(1'b1, 32'h45014501, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            total++; if (instr_vld !== 1'b1) begin bad++; $display("FAIL cli_vld[%0d] got=%b want=1", i, instr_vld); end
            total++; if (instr_pc !== 32'(2 * i)) begin bad++; $display("FAIL cli_pc[%0d] got=%h want=%h", i, instr_pc, 2 * i); end
            total++; if (instr_data[15:0] !== 16'h4501) begin bad++; $display("FAIL cli_data[%0d] got=%h want=4501", i, instr_data[15:0]); end
            drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            total++; if (fetch_rdy !== 1'b1) begin bad++; $display("FAIL cli_rdy[%0d] got=%b want=1", i, fetch_rdy); end
            tick();
        end
        idle();
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL cli_end got=%b want=0", instr_vld); end
    endtask

    task automatic test_straddle();
        do_jump(32'h0);
        drv(1'b1, 32'h00134501, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL strad_wait got=%b want=0", instr_vld); end
        drv(1'b1, 32'h00000000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        total++; if (instr_vld !== 1'b1) begin bad++; $display("FAIL strad_vld got=%b want=1", instr_vld); end
        total++; if (instr_data !== 32'h00000013) begin bad++; $display("FAIL strad_data got=%h want=00000013", instr_data); end
        total++; if (instr_pc !== 32'h2) begin bad++; $display("FAIL strad_pc got=%h want=2", instr_pc); end
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_jump();
        do_jump(32'h0);
        drv(1'b1, 32'h45014501, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 32'hdeadbeef, 1'b0, 1'b1, 32'h00000102, 1'b1, 1'b0);
        tick();
        idle();
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL jump_flush got=%b want=0", instr_vld); end
        total++; if (instr_pc !== 32'h102) begin bad++; $display("FAIL jump_pc got=%h want=102", instr_pc); end
        drv(1'b1, 32'h45051234, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        total++; if (instr_vld !== 1'b1) begin bad++; $display("FAIL jump_vld got=%b want=1", instr_vld); end
        total++; if (instr_data !== 32'h00004505) begin bad++; $display("FAIL jump_skip got=%h want=00004505", instr_data); end
        total++; if (instr_pc !== 32'h102) begin bad++; $display("FAIL jump_pc2 got=%h want=102", instr_pc); end
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        total++; if (instr_pc !== 32'h104) begin bad++; $display("FAIL jump_pc3 got=%h want=104", instr_pc); end
    endtask

    task automatic test_err();
        do_jump(32'h0);
        drv(1'b1, 32'h00134501, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drv(1'b1, 32'h00000000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        total++; if (instr_vld !== 1'b1) begin bad++; $display("FAIL err_hi_vld got=%b want=1", instr_vld); end
        total++; if (instr_err !== 1'b1) begin bad++; $display("FAIL err_hi_err got=%b want=1", instr_err); end
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        do_jump(32'h2);
        drv(1'b1, 32'h0013ffff, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        total++; if (instr_vld !== 1'b1) begin bad++; $display("FAIL err0_vld got=%b want=1", instr_vld); end
        total++; if (instr_err !== 1'b1) begin bad++; $display("FAIL err0_err got=%b want=1", instr_err); end
        total++; if (instr_data !== 32'h00000013) begin bad++; $display("FAIL err0_data got=%h want=00000013", instr_data); end
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        idle();
        total++; if (instr_pc !== 32'h6) begin bad++; $display("FAIL err0_pc got=%h want=6", instr_pc); end
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL err0_empty got=%b want=0", instr_vld); end
    endtask

    task automatic test_back_to_back();
        do_jump(32'h0);
        drv(1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            total++; if (instr_vld !== 1'b1) begin bad++; $display("FAIL b2b_vld[%0d] got=%b want=1", i, instr_vld); end
            total++; if (instr_pc !== 32'(4 * i)) begin bad++; $display("FAIL b2b_pc[%0d] got=%h want=%h", i, instr_pc, 4 * i); end
            drv(1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            #1;
            total++; if (fetch_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy[%0d] got=%b want=1", i, fetch_rdy); end
            tick();
        end
        idle();
    endtask

    task automatic test_no_ext();
        n_jump_now = 1'b1; n_jump_target = 32'h102;
        tick();
        n_jump_now = 1'b0;
        total++; if (n_instr_pc !== 32'h102) begin bad++; $display("FAIL noc_pc got=%h want=102", n_instr_pc); end
        total++; if (n_instr_vld !== 1'b0) begin bad++; $display("FAIL noc_empty got=%b want=0", n_instr_vld); end
        n_fetch_vld = 1'b1; n_fetch_data = 32'h45051234;
        tick();
        n_fetch_vld = 1'b0;
        total++; if (n_instr_vld !== 1'b1) begin bad++; $display("FAIL noc_vld got=%b want=1", n_instr_vld); end
        total++; if (n_instr_data !== 32'h45051234) begin bad++; $display("FAIL noc_noskip got=%h want=45051234", n_instr_data); end
        n_dispatch = 1'b1; n_dispatch_32 = 1'b0;
        tick();
        n_dispatch = 1'b0;
        total++; if (n_instr_pc !== 32'h106) begin bad++; $display("FAIL noc_pc2 got=%h want=106", n_instr_pc); end
        total++; if (n_instr_vld !== 1'b0) begin bad++; $display("FAIL noc_drained got=%b want=0", n_instr_vld); end
    endtask

    task automatic test_random();
        logic d;
        for (int i = 0; i < 3000; i++) begin
            total++; if (instr_vld !== m_vld()) begin bad++; $display("FAIL rnd_vld[%0d] got=%b want=%b", i, instr_vld, m_vld()); end
            total++; if (instr_data !== m_data()) begin bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, instr_data, m_data()); end
            total++; if (instr_err !== m_err()) begin bad++; $display("FAIL rnd_err[%0d] got=%b want=%b", i, instr_err, m_err()); end
            total++; if (instr_pc !== mpc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h want=%h", i, instr_pc, mpc); end
            d = m_vld() && ($urandom_range(0, 3) != 0);
            drv($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0,
                $urandom_range(0, 31) == 0, $urandom, d,
                d && (mq.size() > 0) && (mq[0][1:0] == 2'b11));
            #1;
            total++; if (fetch_rdy !== m_rdy()) begin bad++; $display("FAIL rnd_rdy[%0d] got=%b want=%b", i, fetch_rdy, m_rdy()); end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_jump(32'h40);
        drv(1'b1, 32'h45014501, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        #3 rst_n = 1'b0;
        #1;
        total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL arst_vld got=%b want=0", instr_vld); end
        total++; if (instr_data !== 32'h0) begin bad++; $display("FAIL arst_data got=%h want=0", instr_data); end
        total++; if (instr_pc !== RV) begin bad++; $display("FAIL arst_pc got=%h want=%h", instr_pc, RV); end
        total++; if (fetch_rdy !== 1'b1) begin bad++; $display("FAIL arst_rdy got=%b want=1", fetch_rdy); end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        idle();
        n_fetch_vld = 1'b0; n_fetch_data = 32'h0; n_fetch_err = 1'b0; n_jump_now = 1'b0;
        n_jump_target = 32'h0; n_dispatch = 1'b0; n_dispatch_32 = 1'b0;
        m_reset();
        test_reset();
        test_addi();
        test_two_cli();
        test_straddle();
        test_jump();
        test_err();
        test_back_to_back();
        test_no_ext();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard3_fetch_aligner.md
# hazard3_fetch_aligner

Halfword-granular instruction buffer between the bus-side fetch queue and `hazard3_instr_decompress`. It accepts 32-bit aligned fetch words and holds up to three halfwords. It presents a 32-bit, halfword-aligned instruction window with its PC to the decompressor, and retires 2 or 4 bytes per dispatch. It handles jumps to halfword-aligned targets and carries bus errors per halfword.

## Interface
Parameters:
- `EXTENSION_C`, default 1: enables halfword alignment and 16-bit retirement.
- `RESET_VECTOR`, default 32'h0: PC after reset.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fetch_vld` in 1: fetch word valid.
- `fetch_rdy` out 1: aligner can accept a word this cycle.
- `fetch_data` in 32: fetched word; halfword 0 is `[15:0]`.
- `fetch_err` in 1: bus error on this word.
- `jump_now` in 1: flush and redirect.
- `jump_target` in 32: new PC; bit 0 is ignored.
- `instr_vld` out 1: the window holds a complete instruction.
- `instr_data` out 32: window; halfwords not present are driven as 0.
- `instr_err` out 1: a halfword the instruction needs carries an error.
- `instr_pc` out 32: PC of `instr_data[15:0]`.
- `dispatch` in 1: consume the current instruction.
- `dispatch_32` in 1: size of the consumed instruction; this is `instr_is_32bit` from the decompressor.

## Operation
State:
- `buf[0..2]`: 16-bit halfwords, each with an error bit.
- `level`: 0..3.
- `skip_lo`: 1 bit.
- `pc`: 32 bits.

Window and validity:
- `instr_data` = {buf[1], buf[0]}, masked by `level`.
- `instr_vld` = level≥2, or (level==1 and (buf[0][1:0]!=2'b11 or err0)).
- With `EXTENSION_C`=0, `instr_vld` = level≥2.
- `instr_err` = err0 | (err1 & buf[0][1:0]==2'b11 & level≥2).

Consumption:
- `consumed_hw` = dispatch ? (dispatch_32 ? 2 : 1) : 0.
- With `EXTENSION_C`=0, `consumed_hw` is always 2.
- On consumption, remaining halfwords shift down and `pc` += 2×consumed_hw, wrapping mod 2^32.
- `fetch_rdy` = (level − consumed_hw) ≤ 1. This is combinational from `dispatch` and `dispatch_32`.

Accepting a fetch word (`fetch_vld & fetch_rdy & !jump_now`):
- Both halfwords are appended after the surviving entries and `level` increases by 2.
- If `skip_lo` is set, only `[31:16]` is appended, `level` increases by 1, and `skip_lo` clears.
- Both halfwords inherit `fetch_err`.

Jump (`jump_now`):
- Overrides everything else in that cycle: `level` ← 0, and any `dispatch` or accepted word in that cycle is discarded.
- `pc` ← {jump_target[31:1], 0}.
- `skip_lo` ← jump_target[1] & EXTENSION_C.
- The fetch queue supplies the word containing the target, at an aligned address.

Illegal conditions, which are assertions and ignored in RTL:
- `dispatch` while `!instr_vld`.
- `dispatch_32` with level<2 and err0 clear.

Uop sequences need no special handling: the consumer holds `dispatch` low until the final uop.

## Timing
- Reset values: `level`=0, `skip_lo`=0, `pc`=`RESET_VECTOR`.
- Outputs at reset: `instr_vld`=0, `instr_data`=0, `instr_err`=0, `fetch_rdy`=1.
- Latency:
  - A word accepted in cycle N is visible on `instr_*` in cycle N+1.
  - `instr_*` are driven from registers only.
- Throughput:
  - One dispatch per cycle for any mix of sizes, given one fetch word per cycle.
  - The 3-halfword depth covers a 32-bit instruction that straddles words.
- Simultaneous dispatch and accept in the same cycle is legal. The new data lands at index level − consumed_hw.
- Level is never exceeded: accept requires level − consumed_hw ≤ 1, so the post-update level is ≤ 3.
- `rst_n` asserted mid-stream: all state returns to reset values immediately (asynchronous reset).

## Structure
- Buffer depth (3) and the halfword width are local constants.
- `EXTENSION_C` and `RESET_VECTOR` come from the shared `hazard3_config.vh` parameter list.
- The 2'b11 length predicate is shared with the decompressor via `rv_opcodes.vh`.
- No sub-module: the buffer, shifter and PC counter are a single flat block.

## Test plan
- Reset, then fetch 32'h00000013 (addi) → next cycle `instr_vld`=1, `instr_pc`=`RESET_VECTOR`; dispatch with dispatch_32=1 → level 0.
- Fetch 32'h45014501 (two c.li) with back-to-back dispatch_32=0 → PCs 0, 2; `fetch_rdy` stays 1; one dispatch per cycle sustained.
- Straddle: fetch 32'h00134501, then 32'h00000000 → c.li at pc 0, then `instr_data`=32'h00000013 at pc 2 only once the second word arrives.
- Jump to 32'h102 with the same-cycle fetch and dispatch asserted → both discarded; the next word's low half is skipped; `instr_pc`=32'h102.
- Word with `fetch_err`=1 arriving as the upper half of a 32-bit instruction → `instr_vld`=1, `instr_err`=1; with err0 set alone at level 1 → `instr_vld`=1.
- `EXTENSION_C`=0: `jump_target`=32'h102 → `skip_lo` stays 0, and `instr_vld` requires level 2.
